// File: rtl/riscv_pkg.sv
// Shared RV32 definitions used by fetch and decode.
package riscv_pkg;

  localparam int          XLEN             = 32;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0100_0000;
  localparam logic [31:0] NOP              = 32'h0000_0013;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_t;

  function automatic logic is_word_aligned(input logic [XLEN-1:0] addr);
    return addr[1:0] == 2'b00;
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Bus bundle between fetch and its neighbours: imem request/response, decode handshake, redirect.
interface fetch_unit_if;
  import riscv_pkg::*;

  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [XLEN-1:0] imem_rsp_data;
  logic            instr_valid;
  logic            instr_ready;
  logic [XLEN-1:0] instruction;
  logic [XLEN-1:0] instr_pc;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            fetch_fault;

  modport master (
    output imem_req_valid, imem_req_addr, instr_valid, instruction, instr_pc, fetch_fault,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, instr_ready, redirect_valid, redirect_pc
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, instr_valid, instruction, instr_pc, fetch_fault,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, instr_ready, redirect_valid, redirect_pc
  );

endinterface

// File: rtl/fetch_fifo.sv
// Synchronous instruction FIFO holding {word, pc}; a pop frees its slot for a same-cycle push.
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 32
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic [WIDTH-1:0]       push_pc,
  input  logic                   pop,
  output logic [WIDTH-1:0]       head_data,
  output logic [WIDTH-1:0]       head_pc,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] data_mem [DEPTH];
  logic [WIDTH-1:0] pc_mem   [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty     = (count == '0);
  assign full      = (count == (AW+1)'(DEPTH));
  assign do_pop    = pop && !empty;
  assign do_push   = push && (!full || do_pop);
  assign head_data = data_mem[rd_ptr];
  assign head_pc   = pc_mem[rd_ptr];

  // Storage is cleared on reset so the head outputs read zero out of reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        data_mem[i] <= '0;
        pc_mem[i]   <= '0;
      end
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        data_mem[wr_ptr] <= push_data;
        pc_mem[wr_ptr]   <= push_pc;
        wr_ptr           <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (do_push && !do_pop) begin
        count <= count + 1'b1;
      end else if (do_pop && !do_push) begin
        count <= count - 1'b1;
      end
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC, credit-limited imem requests, wrong-path response dropping and
// a small FIFO feeding decode.
module fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter int          BUF_DEPTH = 2,
  parameter int          MAX_OUTST = 2
) (
  input logic          clock,
  input logic          reset,
  fetch_unit_if.master bus
);

  localparam int OW = $clog2(MAX_OUTST + 1);
  localparam int PW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;

  fetch_state_t          state_q, state_d;
  logic [XLEN-1:0]       pc_q;
  logic [OW-1:0]         outst_q, outst_next;
  logic [OW-1:0]         drop_q;
  logic [XLEN-1:0]       pcq_mem [MAX_OUTST];
  logic [PW-1:0]         pcq_wr, pcq_rd;

  logic                  redirect_ok;
  logic                  redirect_bad;
  logic                  credit_ok;
  logic                  req_valid;
  logic                  req_fire;
  logic                  rsp;
  logic                  fifo_push;
  logic                  fifo_pop;
  logic [XLEN-1:0]       credit_used;
  logic [XLEN-1:0]       head_data, head_pc;
  logic [$clog2(BUF_DEPTH):0] fifo_count;
  logic                  fifo_full, fifo_empty;

  assign rsp          = bus.imem_rsp_valid;
  assign redirect_ok  = (state_q == RUN) && bus.redirect_valid && is_word_aligned(bus.redirect_pc);
  assign redirect_bad = (state_q == RUN) && bus.redirect_valid && !is_word_aligned(bus.redirect_pc);

  // Reserving a FIFO slot per outstanding request means a kept response can always be pushed.
  assign credit_used = XLEN'(outst_q) + XLEN'(fifo_count);
  assign credit_ok   = (credit_used < XLEN'(BUF_DEPTH)) && (XLEN'(outst_q) < XLEN'(MAX_OUTST));

  // FSM next state and request enable; a redirect always suppresses issue that cycle.
  always_comb begin
    state_d   = state_q;
    req_valid = 1'b0;
    unique case (state_q)
      BOOT: state_d = RUN;
      RUN: begin
        if (redirect_bad) begin
          state_d = HALT;
        end
        req_valid = credit_ok && !bus.redirect_valid;
      end
      HALT:    state_d = HALT;
      default: state_d = BOOT;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= BOOT;
    end else begin
      state_q <= state_d;
    end
  end

  assign req_fire   = req_valid && bus.imem_req_ready;
  assign outst_next = outst_q + OW'(req_fire) - OW'(rsp);
  assign fifo_push  = rsp && (drop_q == '0) && !redirect_ok;
  assign fifo_pop   = bus.instr_valid && bus.instr_ready;

  // Every response retires a PC-queue entry, dropped or not, so the queue stays aligned with imem order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc_q    <= RESET_PC;
      outst_q <= '0;
      drop_q  <= '0;
      pcq_wr  <= '0;
      pcq_rd  <= '0;
      for (int i = 0; i < MAX_OUTST; i++) begin
        pcq_mem[i] <= '0;
      end
    end else begin
      outst_q <= outst_next;
      if (redirect_ok) begin
        pc_q   <= bus.redirect_pc;
        drop_q <= outst_next;
      end else begin
        if (req_fire) begin
          pc_q <= pc_q + 32'd4;
        end
        if (rsp && (drop_q != '0)) begin
          drop_q <= drop_q - OW'(1);
        end
      end
      if (req_fire) begin
        pcq_mem[pcq_wr] <= pc_q;
        pcq_wr          <= (pcq_wr == PW'(MAX_OUTST - 1)) ? '0 : pcq_wr + 1'b1;
      end
      if (rsp) begin
        pcq_rd <= (pcq_rd == PW'(MAX_OUTST - 1)) ? '0 : pcq_rd + 1'b1;
      end
    end
  end

  fetch_fifo #(
    .DEPTH (BUF_DEPTH),
    .WIDTH (XLEN)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .flush     (redirect_ok),
    .push      (fifo_push && (!fifo_full || fifo_pop)),
    .push_data (bus.imem_rsp_data),
    .push_pc   (pcq_mem[pcq_rd]),
    .pop       (fifo_pop),
    .head_data (head_data),
    .head_pc   (head_pc),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign bus.imem_req_valid = req_valid;
  assign bus.imem_req_addr  = pc_q;
  assign bus.instr_valid    = !fifo_empty;
  assign bus.instruction    = head_data;
  assign bus.instr_pc       = head_pc;
  assign bus.fetch_fault    = (state_q == HALT);

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a latency-configurable imem model plus an expected {pc, word} queue.
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0100_0000;

  typedef struct {
    int          due;
    logic [31:0] data;
  } mem_rsp_t;

  logic clock = 1'b0;
  logic reset = 1'b1;

  fetch_unit_if bus ();

  fetch_unit #(
    .RESET_PC  (RESET_PC),
    .BUF_DEPTH (2),
    .MAX_OUTST (2)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  mem_rsp_t    mem_q[$];
  logic [63:0] exp_q[$];
  logic [31:0] exp_pc;
  logic        mem_ready;
  int          lat;
  int          cyc;
  int          pops;
  bit          halted;
  bit          expect_flushed;
  int          total;
  int          bad;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'h5a5a, a[31:16] + a[15:0]};
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s: got %h want %h", tag, got, want);
    end
  endtask

  // One clock cycle, entered and left at a negedge: drive, settle, score, then advance.
  task automatic applyStimulus(input logic rdy, input logic rv, input logic [31:0] rpc);
    logic [63:0] head;
    if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_data  = mem_q[0].data;
      void'(mem_q.pop_front());
    end else begin
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data  = '0;
    end
    bus.instr_ready    = rdy;
    bus.redirect_valid = rv;
    bus.redirect_pc    = rpc;
    bus.imem_req_ready = mem_ready;
    #1;
    if (expect_flushed) begin
      checkOutput("flush_valid", 64'(bus.instr_valid), 64'd0);
      expect_flushed = 1'b0;
    end
    if (bus.instr_valid && rdy) begin
      pops++;
      if (exp_q.size() == 0) begin
        checkOutput("extra_word", 64'(bus.instr_valid), 64'd0);
      end else begin
        head = exp_q.pop_front();
        checkOutput("word", {bus.instr_pc, bus.instruction}, head);
      end
    end
    if (bus.imem_req_valid) begin
      if (rv || halted) begin
        checkOutput("req_blocked", 64'(bus.imem_req_valid), 64'd0);
      end else if (mem_ready) begin
        checkOutput("req_addr", 64'(bus.imem_req_addr), 64'(exp_pc));
        exp_q.push_back({exp_pc, mem_word(exp_pc)});
        mem_q.push_back('{cyc + lat, mem_word(bus.imem_req_addr)});
        exp_pc = exp_pc + 32'd4;
      end
    end
    if (rv && !halted) begin
      if (rpc[1:0] == 2'b00) begin
        exp_q.delete();
        exp_pc         = rpc;
        expect_flushed = 1'b1;
      end else begin
        halted = 1'b1;
      end
    end
    @(posedge clock);
    @(negedge clock);
    cyc++;
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_req_valid"}, 64'(bus.imem_req_valid), 64'd0);
    checkOutput({tag, "_instr_valid"}, 64'(bus.instr_valid), 64'd0);
    checkOutput({tag, "_fault"}, 64'(bus.fetch_fault), 64'd0);
    checkOutput({tag, "_instr"}, 64'(bus.instruction), 64'd0);
    checkOutput({tag, "_pc"}, 64'(bus.instr_pc), 64'd0);
  endtask

  task automatic waitForValid(input string tag, input logic [31:0] want_pc);
    for (int i = 0; i < 20 && !bus.instr_valid; i++) begin
      applyStimulus(1'b0, 1'b0, 32'h0);
    end
    checkOutput({tag, "_valid"}, 64'(bus.instr_valid), 64'd1);
    checkOutput({tag, "_pc"}, 64'(bus.instr_pc), 64'(want_pc));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    bit found;
    total = 0; bad = 0; cyc = 0; pops = 0;
    halted = 1'b0; expect_flushed = 1'b0;
    lat = 1; mem_ready = 1'b1; exp_pc = RESET_PC;
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = '0;
    bus.instr_ready    = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;

    @(negedge clock);
    #1;
    checkResetOutputs("reset");
    @(negedge clock);
    reset = 1'b0;
    #1;
    checkOutput("boot_no_req", 64'(bus.imem_req_valid), 64'd0);

    $display("[TB] test 1: in-order stream");
    applyStimulus(1'b1, 1'b0, 32'h0);
    checkOutput("first_req_valid", 64'(bus.imem_req_valid), 64'd1);
    checkOutput("first_req_addr", 64'(bus.imem_req_addr), 64'(RESET_PC));
    pops = 0;
    for (int i = 0; i < 30; i++) applyStimulus(1'b1, 1'b0, 32'h0);
    checkOutput("stream_progress", 64'(pops >= 10), 64'd1);
    checkOutput("no_fault", 64'(bus.fetch_fault), 64'd0);

    $display("[TB] test 2: decode stall");
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("stall_req_valid", 64'(bus.imem_req_valid), 64'd0);
    checkOutput("stall_instr_valid", 64'(bus.instr_valid), 64'd1);
    checkOutput("stall_fill", 64'(exp_q.size()), 64'd2);
    for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b0, 32'h0);

    $display("[TB] test 3: redirect with two in flight");
    lat = 2;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (mem_q.size() == 2) found = 1'b1;
      else applyStimulus(1'b1, 1'b0, 32'h0);
    end
    checkOutput("t3_setup", 64'(found), 64'd1);
    applyStimulus(1'b1, 1'b1, 32'h0100_0100);
    waitForValid("t3_redirect", 32'h0100_0100);
    for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b0, 32'h0);

    $display("[TB] test 4: redirect with response and pop");
    lat = 1;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (bus.instr_valid && mem_q.size() > 0 && mem_q[0].due <= cyc) found = 1'b1;
      else applyStimulus(1'b1, 1'b0, 32'h0);
    end
    checkOutput("t4_setup", 64'(found), 64'd1);
    applyStimulus(1'b1, 1'b1, 32'h0100_0200);
    waitForValid("t4_redirect", 32'h0100_0200);

    $display("[TB] test 5: random traffic");
    for (int i = 0; i < 300; i++) begin
      mem_ready = 1'($urandom_range(0, 3) != 0);
      lat = int'($urandom_range(1, 2));
      if ($urandom_range(0, 29) == 0)
        applyStimulus(1'($urandom_range(0, 1)), 1'b1, RESET_PC + 32'($urandom_range(0, 63)) * 32'd4);
      else
        applyStimulus(1'($urandom_range(0, 1)), 1'b0, 32'h0);
    end
    mem_ready = 1'b1;
    lat = 1;

    $display("[TB] test 6: misaligned redirect");
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b1, 32'h0100_0102);
    checkOutput("fault_set", 64'(bus.fetch_fault), 64'd1);
    for (int i = 0; i < 5; i++) begin
      checkOutput("halt_no_req", 64'(bus.imem_req_valid), 64'd0);
      applyStimulus(1'b0, 1'b0, 32'h0);
    end
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) applyStimulus(1'b1, 1'b0, 32'h0);
    checkOutput("halt_drained", 64'(exp_q.size()), 64'd0);
    applyStimulus(1'b1, 1'b0, 32'h0);
    checkOutput("halt_empty", 64'(bus.instr_valid), 64'd0);
    checkOutput("fault_sticky", 64'(bus.fetch_fault), 64'd1);

    $display("[TB] test 7: reset mid-stream");
    reset = 1'b1;
    #1;
    reset = 1'b0;
    halted = 1'b0; exp_q.delete(); mem_q.delete(); exp_pc = RESET_PC;
    @(negedge clock);
    lat = 2;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (mem_q.size() == 2) found = 1'b1;
      else applyStimulus(1'b1, 1'b0, 32'h0);
    end
    checkOutput("t7_setup", 64'(found), 64'd1);
    reset = 1'b1;
    #1;
    checkResetOutputs("midreset");
    mem_q.delete(); exp_q.delete(); exp_pc = RESET_PC;
    bus.imem_rsp_valid = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    #1;
    checkOutput("reboot_no_req", 64'(bus.imem_req_valid), 64'd0);
    applyStimulus(1'b1, 1'b0, 32'h0);
    checkOutput("reboot_req_valid", 64'(bus.imem_req_valid), 64'd1);
    checkOutput("reboot_req_addr", 64'(bus.imem_req_addr), 64'(RESET_PC));
    for (int i = 0; i < 20; i++) applyStimulus(1'b1, 1'b0, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
